// File: rtl/ins_mem_loader.sv
// Instruction-memory writer: packs a valid/ready byte stream big-endian into
// 32-bit words, writes them at sequential word addresses and stalls the CPU meanwhile.
module ins_mem_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Start,
  input  logic [7:0]        ByteIn,
  input  logic              ByteValid,
  input  logic              ByteLast,
  output logic              ByteReady,
  output logic              MemWE,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemData,
  output logic              CpuHold,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic [ADDR_W:0]   WordsLoaded
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state;
  state_t            stateNext;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addrNext;
  logic [1:0]        byteCnt;
  logic [1:0]        byteCntNext;
  logic [31:0]       word;
  logic [31:0]       wordNext;
  logic              lastFlag;
  logic              lastFlagNext;
  logic [ADDR_W:0]   wordsLoadedNext;
  logic              xfer;

  // ByteReady is the registered image of state==RECV, so it is the handshake term.
  assign xfer = ByteValid && ByteReady;

  // Next-state, datapath and word-count decisions.
  always_comb begin
    stateNext       = state;
    addrNext        = addr;
    byteCntNext     = byteCnt;
    wordNext        = word;
    lastFlagNext    = lastFlag;
    wordsLoadedNext = WordsLoaded;
    case (state)
      IDLE, DONE, ERR: begin
        if (Start) begin
          stateNext       = RECV;
          addrNext        = {ADDR_W{1'b0}};
          byteCntNext     = 2'd0;
          lastFlagNext    = 1'b0;
          wordsLoadedNext = {(ADDR_W+1){1'b0}};
        end else begin
          stateNext = state;
        end
      end
      RECV: begin
        if (xfer) begin
          wordNext = {word[23:0], ByteIn};
          if (byteCnt == 2'd3) begin
            stateNext    = WRITE;
            lastFlagNext = ByteLast;
          end else if (ByteLast) begin
            // Program ended mid-word: abort without writing the fragment.
            stateNext       = ERR;
            wordsLoadedNext = {1'b0, addr};
          end else begin
            byteCntNext = byteCnt + 2'd1;
          end
        end else begin
          stateNext = RECV;
        end
      end
      WRITE: begin
        if (lastFlag) begin
          stateNext       = DONE;
          wordsLoadedNext = {1'b0, addr} + COUNT_ONE;
        end else if (addr == ADDR_MAX) begin
          stateNext       = ERR;
          wordsLoadedNext = {1'b0, addr} + COUNT_ONE;
        end else begin
          stateNext   = RECV;
          addrNext    = addr + ADDR_ONE;
          byteCntNext = 2'd0;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State, datapath and registered output updates.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state       <= IDLE;
      addr        <= {ADDR_W{1'b0}};
      byteCnt     <= 2'd0;
      word        <= 32'd0;
      lastFlag    <= 1'b0;
      ByteReady   <= 1'b0;
      MemWE       <= 1'b0;
      MemAddr     <= {ADDR_W{1'b0}};
      MemData     <= 32'd0;
      CpuHold     <= 1'b0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      Error       <= 1'b0;
      WordsLoaded <= {(ADDR_W+1){1'b0}};
    end else begin
      state       <= stateNext;
      addr        <= addrNext;
      byteCnt     <= byteCntNext;
      word        <= wordNext;
      lastFlag    <= lastFlagNext;
      ByteReady   <= (stateNext == RECV);
      MemWE       <= (stateNext == WRITE);
      CpuHold     <= (stateNext == RECV) || (stateNext == WRITE) || (stateNext == ERR);
      Busy        <= (stateNext == RECV) || (stateNext == WRITE);
      Done        <= (stateNext == DONE);
      Error       <= (stateNext == ERR);
      WordsLoaded <= wordsLoadedNext;
      if (stateNext == WRITE) begin
        MemAddr <= addr;
        MemData <= wordNext;
      end
    end
  end

endmodule

// File: tb/tb_ins_mem_loader.sv
// Directed bench for ins_mem_loader with a write scoreboard; a second instance
// with ADDR_W=2 covers the memory-full abort.
module tb_ins_mem_loader;

  logic       CLK = 1'b0;
  logic       Reset;
  logic       startA;
  logic       startB;
  logic [7:0] ByteIn;
  logic       ByteValid;
  logic       ByteLast;

  logic        readyA, weA, holdA, busyA, doneA, errA;
  logic [5:0]  addrA;
  logic [31:0] dataA;
  logic [6:0]  wlA;
  logic        readyB, weB, holdB, busyB, doneB, errB;
  logic [1:0]  addrB;
  logic [31:0] dataB;
  logic [2:0]  wlB;

  int total = 0;
  int bad = 0;
  int weCntA = 0;
  int weCntB = 0;
  logic [39:0] qA[$];
  logic [39:0] qB[$];

  always #5 CLK = ~CLK;

  ins_mem_loader #(.ADDR_W(6)) dutA (
    .CLK(CLK), .Reset(Reset), .Start(startA), .ByteIn(ByteIn),
    .ByteValid(ByteValid), .ByteLast(ByteLast), .ByteReady(readyA),
    .MemWE(weA), .MemAddr(addrA), .MemData(dataA), .CpuHold(holdA),
    .Busy(busyA), .Done(doneA), .Error(errA), .WordsLoaded(wlA)
  );

  ins_mem_loader #(.ADDR_W(2)) dutB (
    .CLK(CLK), .Reset(Reset), .Start(startB), .ByteIn(ByteIn),
    .ByteValid(ByteValid), .ByteLast(ByteLast), .ByteReady(readyB),
    .MemWE(weB), .MemAddr(addrB), .MemData(dataB), .CpuHold(holdB),
    .Busy(busyB), .Done(doneB), .Error(errB), .WordsLoaded(wlB)
  );

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe cycle must match the next queued write.
  always @(negedge CLK) begin
    if (weA === 1'b1) begin
      weCntA++;
      if (qA.size() == 0) check("unexpWrA", {2'b0, addrA, dataA}, 40'hFF_FFFF_FFFF);
      else check("wrA", {2'b0, addrA, dataA}, qA.pop_front());
    end
    if (weB === 1'b1) begin
      weCntB++;
      if (qB.size() == 0) check("unexpWrB", {6'b0, addrB, dataB}, 40'hFF_FFFF_FFFF);
      else check("wrB", {6'b0, addrB, dataB}, qB.pop_front());
    end
  end

  task automatic pulseStart(input bit sel);
    @(posedge CLK); #1;
    if (sel) startB = 1'b1; else startA = 1'b1;
    @(posedge CLK); #1;
    startA = 1'b0;
    startB = 1'b0;
  endtask

  task automatic sendByte(input bit sel, input logic [7:0] b, input bit last,
                          input int budget, output bit ok);
    ByteIn = b; ByteLast = last; ByteValid = 1'b1; ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge CLK);
      ok = sel ? readyB : readyA;
      @(posedge CLK); #1;
    end
    ByteValid = 1'b0;
    ByteLast = 1'b0;
  endtask

  task automatic sendChk(input bit sel, input logic [7:0] b, input bit last);
    bit ok;
    sendByte(sel, b, last, 20, ok);
    check("byteAccepted", {39'd0, ok}, 40'd1);
  endtask

  task automatic waitFlag(input bit sel, input bit wantErr, input string tag);
    bit f;
    f = 1'b0;
    for (int i = 0; i < 40 && !f; i++) begin
      @(negedge CLK);
      f = sel ? (wantErr ? errB : doneB) : (wantErr ? errA : doneA);
    end
    check(tag, {39'd0, f}, 40'd1);
  endtask

  initial begin
    bit ok;
    int weBefore;
    Reset = 1'b1; startA = 1'b0; startB = 1'b0;
    ByteIn = 8'h00; ByteValid = 1'b0; ByteLast = 1'b0;
    repeat (2) @(posedge CLK);
    #1 Reset = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rstReady", {39'd0, readyA}, 40'd0);
    check("rstWE", {39'd0, weA}, 40'd0);
    check("rstFlags", {36'd0, holdA, busyA, doneA, errA}, 40'd0);
    check("rstAddrData", {2'b0, addrA, dataA}, 40'd0);
    check("rstWords", {33'd0, wlA}, 40'd0);

    // Single word, ByteValid held high
    pulseStart(1'b0);
    qA.push_back({8'd0, 32'h8C010004});
    @(negedge CLK);
    check("recvFlags", {37'd0, holdA, busyA, readyA}, 40'h7);
    @(posedge CLK); #1;
    sendChk(1'b0, 8'h8C, 1'b0);
    sendChk(1'b0, 8'h01, 1'b0);
    sendChk(1'b0, 8'h00, 1'b0);
    sendChk(1'b0, 8'h04, 1'b1);
    waitFlag(1'b0, 1'b0, "t1Done");
    check("t1Words", {33'd0, wlA}, 40'd1);
    check("t1HoldBusyErr", {37'd0, holdA, busyA, errA}, 40'd0);
    check("t1WeCount", weCntA, 40'd1);

    // Two words, ByteValid toggling
    pulseStart(1'b0);
    qA.push_back({8'd0, 32'h00010203});
    qA.push_back({8'd1, 32'h04050607});
    for (int i = 0; i < 8; i++) begin
      sendChk(1'b0, i[7:0], i == 7);
      @(posedge CLK); #1;
    end
    waitFlag(1'b0, 1'b0, "t2Done");
    check("t2Words", {33'd0, wlA}, 40'd2);
    check("t2Err", {39'd0, errA}, 40'd0);
    check("t2WeCount", weCntA, 40'd3);

    // Misaligned program: six bytes
    pulseStart(1'b0);
    check("t3DoneCleared", {39'd0, doneA}, 40'd0);
    qA.push_back({8'd0, 32'h10111213});
    for (int i = 0; i < 6; i++) sendChk(1'b0, 8'h10 + i[7:0], i == 5);
    waitFlag(1'b0, 1'b1, "t3Err");
    check("t3Words", {33'd0, wlA}, 40'd1);
    check("t3HoldBusyDone", {37'd0, holdA, busyA, doneA}, 40'h4);
    repeat (3) @(posedge CLK);
    check("t3WeCount", weCntA, 40'd4);

    // Memory full on the 4-word instance
    pulseStart(1'b1);
    for (int w = 0; w < 4; w++)
      qB.push_back({6'd0, w[1:0], 8'(4*w+8'h40), 8'(4*w+8'h41), 8'(4*w+8'h42), 8'(4*w+8'h43)});
    for (int i = 0; i < 16; i++) sendChk(1'b1, 8'h40 + i[7:0], 1'b0);
    sendByte(1'b1, 8'hEE, 1'b0, 6, ok);
    check("fullNoAccept", {39'd0, ok}, 40'd0);
    check("fullErr", {38'd0, errB, holdB}, 40'h3);
    check("fullWords", {37'd0, wlB}, 40'd4);
    check("fullWeCount", weCntB, 40'd4);

    // Reset mid-word aborts without writing
    pulseStart(1'b0);
    sendChk(1'b0, 8'h55, 1'b0);
    sendChk(1'b0, 8'h66, 1'b0);
    weBefore = weCntA;
    Reset = 1'b1;
    @(posedge CLK); #1;
    Reset = 1'b0;
    @(negedge CLK);
    check("midRstWE", {39'd0, weA}, 40'd0);
    check("midRstFlags", {35'd0, busyA, holdA, readyA, doneA, errA}, 40'd0);
    check("midRstNoWrite", weCntA, weBefore);
    pulseStart(1'b0);
    qA.push_back({8'd0, 32'hAABBCCDD});
    sendChk(1'b0, 8'hAA, 1'b0);
    sendChk(1'b0, 8'hBB, 1'b0);
    sendChk(1'b0, 8'hCC, 1'b0);
    sendChk(1'b0, 8'hDD, 1'b1);
    waitFlag(1'b0, 1'b0, "t5Done");
    check("t5Words", {33'd0, wlA}, 40'd1);
    check("qAEmpty", qA.size(), 40'd0);
    check("qBEmpty", qB.size(), 40'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
